// File: rtl/mainfsm_pkg.sv
// Shared types and encodings for the multicycle main controller.
package mc_pkg;

    localparam int unsigned OP_W  = 7;
    localparam int unsigned IMM_W = 3;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LINK,
        S_LUI,
        S_ILLEGAL
    } state_e;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;
    localparam logic [SEL_W-1:0] RES_IMMEXT    = 2'b11;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RD2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] ALUOP_ADD    = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [IMM_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_W-1:0] IMM_J = 3'b011;
    localparam logic [IMM_W-1:0] IMM_U = 3'b100;

    typedef struct packed {
        logic             pc_write;
        logic             adr_src;
        logic             mem_write;
        logic             ir_write;
        logic [SEL_W-1:0] result_src;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic             reg_write;
        logic             illegal;
    } ctrl_t;

    // Dispatch target out of DECODE; anything unsupported traps.
    function automatic state_e decode_next(input logic [OP_W-1:0] op);
        case (op)
            OP_LOAD, OP_STORE: decode_next = S_MEMADR;
            OP_RTYPE:          decode_next = S_EXECR;
            OP_ITYPE:          decode_next = S_EXECI;
            OP_BRANCH:         decode_next = S_BRANCH;
            OP_JAL:            decode_next = S_JAL;
            OP_JALR:           decode_next = S_JALR;
            OP_LUI:            decode_next = S_LUI;
            default:           decode_next = S_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mainfsm_if.sv
// Controller <-> datapath bundle: opcode/status in, control strobes out.
interface mainfsm_if import mc_pkg::*; ();
    logic [OP_W-1:0]  op;
    logic             br_taken;
    logic             mem_ready;
    logic             pc_write;
    logic             adr_src;
    logic             mem_write;
    logic             ir_write;
    logic [SEL_W-1:0] result_src;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic             reg_write;
    logic [IMM_W-1:0] imm_src;
    logic             illegal;

    modport master (
        input  op, br_taken, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, reg_write, imm_src, illegal
    );

    modport slave (
        output op, br_taken, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, reg_write, imm_src, illegal
    );
endinterface

// File: rtl/mainfsm_instrdec.sv
// Immediate-format select decoded combinationally from the opcode.
module instrdec import mc_pkg::*; (
    input  logic [OP_W-1:0]  op,
    output logic [IMM_W-1:0] imm_src
);
    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            OP_LUI:    imm_src = IMM_U;
            default:   imm_src = IMM_I;
        endcase
    end
endmodule

// File: rtl/mainfsm.sv
// Multicycle RISC-V main controller (Moore FSM).
// Optional MEM_WAIT_EN: FETCH/MEMREAD/MEMWRITE stall until mem_ready.
module mainfsm import mc_pkg::*; (
    input  logic      clk,
    input  logic      reset_n,
    mainfsm_if.master bus
);
    state_e           state_q, state_d;
    ctrl_t            ctrl, ctrl_out;
    logic             mem_ok;
    logic [IMM_W-1:0] imm_raw;

`ifdef MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign mem_ok           = 1'b1;
    assign unused_mem_ready = bus.mem_ready;
`endif

    instrdec u_instrdec (
        .op      (bus.op),
        .imm_src (imm_raw)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.ir_write   = mem_ok;
                ctrl.pc_write   = mem_ok;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                if (mem_ok) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_d        = decode_next(bus.op);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_d        = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                ctrl.adr_src = 1'b1;
                if (mem_ok) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                if (mem_ok) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RD2;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                state_d         = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_RD2;
                ctrl.alu_op     = ALUOP_BRANCH;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = bus.br_taken;
                state_d         = S_FETCH;
            end
            S_JALR: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                ctrl.pc_write   = 1'b1;
                state_d         = S_LINK;
            end
            // JAL redirects the PC; LINK only computes OldPC+4 for the writeback.
            S_JAL, S_LINK: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = (state_q == S_JAL);
                state_d         = S_ALUWB;
            end
            S_LUI: begin
                ctrl.result_src = RES_IMMEXT;
                ctrl.reg_write  = 1'b1;
                state_d         = S_FETCH;
            end
            S_ILLEGAL: begin
                ctrl.illegal = 1'b1;
                state_d      = S_ILLEGAL;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are squashed while reset is held so no strobe leaks out.
    assign ctrl_out       = reset_n ? ctrl : '0;
    assign bus.imm_src    = reset_n ? imm_raw : '0;
    assign bus.pc_write   = ctrl_out.pc_write;
    assign bus.adr_src    = ctrl_out.adr_src;
    assign bus.mem_write  = ctrl_out.mem_write;
    assign bus.ir_write   = ctrl_out.ir_write;
    assign bus.result_src = ctrl_out.result_src;
    assign bus.alu_src_a  = ctrl_out.alu_src_a;
    assign bus.alu_src_b  = ctrl_out.alu_src_b;
    assign bus.alu_op     = ctrl_out.alu_op;
    assign bus.reg_write  = ctrl_out.reg_write;
    assign bus.illegal    = ctrl_out.illegal;

endmodule

// File: doc/mainfsm.md
MAINFSM -- requirements
Module: mainfsm

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 reset_n  input  1  reset is asynchronous and active-low.
REQ-003 op  input  7  opcode field of instruction register; stable from end of FETCH until next FETCH.
REQ-004 br_taken  input  1  branch condition from datapath comparator; sampled only in BRANCH.
REQ-005 mem_ready  input  1  memory access complete; used only when MEM_WAIT_EN defined, ignored otherwise.
REQ-006 pc_write  output  1  PC register load enable.
REQ-007 adr_src  output  1  memory address: 0 PC, 1 ALUOut.
REQ-008 mem_write  output  1  data memory write strobe.
REQ-009 ir_write  output  1  instruction/OldPC register load enable.
REQ-010 result_src  output  2  Result mux: 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
REQ-011 alu_src_a  output  2  SrcA: 00 PC, 01 OldPC, 10 RD1.
REQ-012 alu_src_b  output  2  SrcB: 00 RD2, 01 ImmExt, 10 constant 4.
REQ-013 alu_op  output  2  to ALU decoder: 00 add, 01 branch compare, 10 funct-decoded.
REQ-014 reg_write  output  1  register file write enable.
REQ-015 imm_src  output  3  immediate format, combinational from op: lw/I-ALU/jalr 000, sw 001, B 010, jal 011, lui 100, other 000.
REQ-016 illegal  output  1  unsupported opcode trapped; sticky.

Function
REQ-017 Moore FSM; every output not listed for a state SHALL be 0 in that state (imm_src excepted).
REQ-018 FETCH: adr_src 0, ir_write 1, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10, pc_write 1; -> DECODE.
REQ-019 DECODE: alu_src_a 01, alu_src_b 01, alu_op 00 (ALUOut := OldPC+imm); next by op: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, else ILLEGAL.
REQ-020 MEMADR: alu_src_a 10, alu_src_b 01, alu_op 00; -> MEMREAD if op=0000011, else MEMWRITE.
REQ-021 MEMREAD: adr_src 1; -> MEMWB. MEMWB: result_src 01, reg_write 1; -> FETCH.
REQ-022 MEMWRITE: adr_src 1, mem_write 1; -> FETCH.
REQ-023 EXECR: alu_src_a 10, alu_src_b 00, alu_op 10; EXECI identical except alu_src_b 01; both -> ALUWB.
REQ-024 ALUWB: result_src 00, reg_write 1; -> FETCH.
REQ-025 BRANCH: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00, pc_write = br_taken; -> FETCH.
REQ-026 JALR: alu_src_a 10, alu_src_b 01, alu_op 00, result_src 10, pc_write 1; -> JAL-link path LINK (LSB clearing is datapath's job).
REQ-027 JAL: alu_src_a 01, alu_src_b 10, alu_op 00, result_src 00, pc_write 1; -> ALUWB. LINK: same minus pc_write; -> ALUWB.
REQ-028 LUI: result_src 11, reg_write 1; -> FETCH.
REQ-029 ILLEGAL: illegal 1, all enables 0; remains until reset.
REQ-030 Cycle counts (no wait): lw 5, sw 4, R/I 4, B 3, jal 4, jalr 5, lui 3.

Reset
REQ-031 reset_n low: state := FETCH asynchronously; all outputs forced 0 combinationally while low (including illegal); first FETCH cycle is first rising edge after deassertion.
REQ-032 Reset mid-instruction aborts it; no partial write after deassertion.

Configuration
REQ-033 MEM_WAIT_EN defined: FETCH, MEMREAD, MEMWRITE hold while mem_ready=0, keeping their outputs except ir_write/pc_write in FETCH gated by mem_ready; advance on mem_ready=1.
REQ-034 MEM_WAIT_EN undefined: those states last exactly one cycle; mem_ready unused.

Structure
REQ-035 Package mc_pkg: state enum, opcode constants, result_src/alu_src_a/alu_src_b/alu_op encodings.
REQ-036 One sub-module instrdec: combinational op -> imm_src.

Verification
REQ-037 lw (op 0000011) after reset: FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write=1 with result_src=01 only in cycle 5.
REQ-038 beq op 1100011, br_taken=1 then 0: pc_write=1 in cycle 3 for first, 0 for second; both return to FETCH.
REQ-039 jalr: pc_write in cycles 1 and 3, reg_write with result_src=00 in cycle 5.
REQ-040 op 0001111: ILLEGAL after DECODE, illegal=1 held 10+ cycles, cleared by reset_n pulse.
REQ-041 MEM_WAIT_EN, sw with mem_ready low 3 cycles: mem_write held 4 cycles, FETCH next.
REQ-042 reset_n asserted in MEMWB: reg_write drops immediately; FETCH after release.
